vend_controller: RTL and testbench
==================================

VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 Parameter PRICE_1, default 3, price of item 1 in nickel units (15 cents).
REQ-002 Parameter PRICE_2, default 4, price of item 2 in nickel units (20 cents).
REQ-003 Parameter PRICE_3, default 5, price of item 3 in nickel units (25 cents).
REQ-004 Parameter PRICE_4, default 6, price of item 4 in nickel units (30 cents).
REQ-005 clock  input  1  single clock; all state updates occur on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 item_number  input  4  one-hot item select; bit 0 is item 1 and bit 3 is item 4.
REQ-008 select  input  1  one-cycle pulse that latches item_number.
REQ-009 nickel_in  input  1  one-cycle pulse meaning a nickel was inserted.
REQ-010 dime_in  input  1  one-cycle pulse meaning a dime was inserted.
REQ-011 cancel  input  1  one-cycle pulse requesting a refund.
REQ-012 dispense_ack  input  1  level input; the mechanism asserts it when the item is out.
REQ-013 dispense  output  1  level output; requests item release.
REQ-014 nickel_out  output  1  pulse output; one pulse per returned nickel.
REQ-015 coin_reject  output  1  one-cycle pulse meaning the inserted coin was not accepted.
REQ-016 sel_error  output  1  one-cycle pulse meaning the selection was invalid.
REQ-017 credit  output  4  current credit in nickel units.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 The controller SHALL implement the states IDLE, COLLECT, VEND, CHANGE and REFUND.
REQ-020 In IDLE, select with a one-hot item_number SHALL latch that item's price and move to COLLECT on the next edge.
REQ-021 In IDLE, select with a non-one-hot item_number (zero or multi-bit) SHALL pulse sel_error for one cycle and stay in IDLE.
REQ-022 In COLLECT, nickel_in SHALL add 1 to credit, dime_in SHALL add 2, and both in the same cycle SHALL add 3; credit is valid on the cycle after the edge.
REQ-023 In COLLECT, when the updated credit is greater than or equal to the latched price, the controller SHALL enter VEND on the next edge, so dispense rises one cycle after the paying coin.
REQ-024 Credit SHALL NOT exceed price+2 (4 bits wide); all parameter prices SHALL be in the range 1..13.
REQ-025 A coin pulse in IDLE, VEND, CHANGE or REFUND SHALL NOT change credit and SHALL pulse coin_reject for one cycle.
REQ-026 A select pulse outside IDLE SHALL be ignored and SHALL NOT pulse sel_error.
REQ-027 In VEND, dispense SHALL be held high until the cycle in which dispense_ack=1 is sampled.
REQ-028 On that ack, credit SHALL become credit-price; the next state is CHANGE if the result is >0, otherwise IDLE.
REQ-029 In CHANGE and REFUND, nickel_out SHALL be high for 1 cycle then low for 1 cycle per nickel, and credit SHALL decrement on each high cycle.
REQ-030 The controller SHALL return to IDLE on the edge after the pulse that brings credit to 0.
REQ-031 In IDLE, credit SHALL be 0 and dispense and nickel_out SHALL be 0.
REQ-032 Cancel outside COLLECT SHALL be ignored.
REQ-033 When cancel and a coin arrive in the same COLLECT cycle, the coin SHALL be credited first and then refunded.
REQ-034 When cancel and a paying coin coincide, cancel SHALL take precedence.

Reset
REQ-035 reset=1 at a clock edge SHALL force IDLE.
REQ-036 Reset SHALL set credit=0, the latched price=0, and dispense, nickel_out, coin_reject, sel_error and busy all to 0.
REQ-037 Reset SHALL take precedence over every other input and SHALL abort any sequence mid-operation, including an in-progress dispense or change, without paying out the remaining credit.

Configuration
REQ-038 When macro VEND_CANCEL_EN is defined, cancel in COLLECT SHALL enter REFUND when credit>0, and SHALL return to IDLE on the next edge when credit=0.
REQ-039 When VEND_CANCEL_EN is undefined, the cancel input SHALL be ignored in all states, REFUND SHALL be unreachable, and all other behaviour SHALL be identical.

Verification
REQ-040 Item 1 selected, nickel, then dime -> credit goes 1, then 3; dispense rises one cycle later; ack -> IDLE with no nickel_out.
REQ-041 Item 1 selected, dime, then dime -> credit reaches 4; ack -> exactly 1 nickel_out pulse; credit 0; IDLE.
REQ-042 select with item_number=4'b0011 -> one sel_error pulse, state stays IDLE; a nickel in IDLE -> coin_reject pulse, credit stays 0.
REQ-043 Item 4 selected, then nickel_in and dime_in in the same cycle -> credit 3; then dime, dime -> credit 7; ack -> 1 nickel returned.
REQ-044 VEND_CANCEL_EN defined, item 3 selected, dime, then cancel -> 2 nickel_out pulses on alternate cycles, then IDLE; undefined -> cancel has no effect and credit stays 2.
REQ-045 reset asserted during CHANGE with credit 2 -> next cycle IDLE, credit 0, no further nickel_out pulses.

Source files
------------

// File: rtl/vend_controller_if.sv
// Vending controller bus: selection, coin, refund and dispense handshake
// signals between the machine front panel and the controller.
interface vend_controller_if;
    logic [3:0] item_number;
    logic       select;
    logic       nickel_in;
    logic       dime_in;
    logic       cancel;
    logic       dispense_ack;
    logic       dispense;
    logic       nickel_out;
    logic       coin_reject;
    logic       sel_error;
    logic [3:0] credit;
    logic       busy;

    // Front panel / mechanism side
    modport master (
        output item_number, select, nickel_in, dime_in, cancel, dispense_ack,
        input  dispense, nickel_out, coin_reject, sel_error, credit, busy
    );

    // Controller side
    modport slave (
        input  item_number, select, nickel_in, dime_in, cancel, dispense_ack,
        output dispense, nickel_out, coin_reject, sel_error, credit, busy
    );
endinterface

// File: rtl/vend_controller.sv
// Vending machine controller: one-hot item select, nickel/dime collection,
// dispense handshake and nickel-by-nickel change return.
// Optional feature: define VEND_CANCEL_EN to let cancel refund credit
// while collecting; otherwise cancel is ignored and REFUND is unreachable.
module vend_controller #(
    parameter int PRICE_1 = 3,
    parameter int PRICE_2 = 4,
    parameter int PRICE_3 = 5,
    parameter int PRICE_4 = 6
) (
    input logic             clock,
    input logic             reset,
    vend_controller_if.slave bus
);
    typedef enum logic [2:0] {IDLE, COLLECT, VEND, CHANGE, REFUND} state_t;

    state_t     state;
    logic [3:0] price;
    logic [3:0] sel_price;
    logic       sel_valid;
    logic       coin;
    logic [3:0] credit_sum;
    logic       cancel_req;

    // Credit can never exceed price+2 (<=15), so the 4-bit sum cannot wrap.
    assign coin       = bus.nickel_in | bus.dime_in;
    assign credit_sum = bus.credit + {2'b00, bus.dime_in, bus.nickel_in};

`ifdef VEND_CANCEL_EN
    assign cancel_req = bus.cancel;
`else
    logic unused_cancel;
    assign unused_cancel = bus.cancel;
    assign cancel_req    = 1'b0;
`endif

    // Decode the one-hot item select into a price; anything else is invalid.
    always_comb begin
        sel_valid = 1'b1;
        sel_price = '0;
        case (bus.item_number)
            4'b0001: sel_price = 4'(PRICE_1);
            4'b0010: sel_price = 4'(PRICE_2);
            4'b0100: sel_price = 4'(PRICE_3);
            4'b1000: sel_price = 4'(PRICE_4);
            default: sel_valid = 1'b0;
        endcase
    end

    // Controller FSM with all outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            price           <= '0;
            bus.credit      <= '0;
            bus.dispense    <= 1'b0;
            bus.nickel_out  <= 1'b0;
            bus.coin_reject <= 1'b0;
            bus.sel_error   <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            bus.coin_reject <= coin && (state != COLLECT);
            bus.sel_error   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.select) begin
                        if (sel_valid) begin
                            price    <= sel_price;
                            state    <= COLLECT;
                            bus.busy <= 1'b1;
                        end else begin
                            bus.sel_error <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    // Cancel wins over a paying coin; a coin arriving with
                    // cancel is credited and then refunded with the rest.
                    if (cancel_req) begin
                        bus.credit <= credit_sum;
                        if (credit_sum == 4'd0) begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end else begin
                            state <= REFUND;
                        end
                    end else if (coin) begin
                        bus.credit <= credit_sum;
                        if (credit_sum >= price) begin
                            state        <= VEND;
                            bus.dispense <= 1'b1;
                        end
                    end
                end
                VEND: begin
                    if (bus.dispense_ack) begin
                        bus.dispense <= 1'b0;
                        bus.credit   <= bus.credit - price;
                        if (bus.credit > price) begin
                            state <= CHANGE;
                        end else begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end
                    end
                end
                CHANGE, REFUND: begin
                    // One nickel per high cycle, separated by a low cycle.
                    if (!bus.nickel_out) begin
                        bus.nickel_out <= 1'b1;
                        bus.credit     <= bus.credit - 4'd1;
                    end else begin
                        bus.nickel_out <= 1'b0;
                        if (bus.credit == 4'd0) begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller (default prices 3/4/5/6).
module tb_vend_controller;
    logic clock;
    logic reset;
    vend_controller_if bus ();

    vend_controller dut (.clock(clock), .reset(reset), .bus(bus));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    int exp;
    int nick_cnt = 0;
    int nick_b2b = 0;
    int base, base_b2b;
    logic nick_prev = 1'b0;

    // Nickel pulse monitor, sampled mid-cycle
    always @(negedge clock) begin
        if (bus.nickel_out) begin
            nick_cnt++;
            if (nick_prev) nick_b2b++;
        end
        nick_prev = bus.nickel_out;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_select(input logic [3:0] item);
        bus.item_number = item;
        bus.select      = 1'b1;
        tick();
        bus.select      = 1'b0;
        bus.item_number = 4'b0000;
    endtask

    task automatic do_coin(input logic n, input logic d, input logic c);
        bus.nickel_in = n;
        bus.dime_in   = d;
        bus.cancel    = c;
        tick();
        bus.nickel_in = 1'b0;
        bus.dime_in   = 1'b0;
        bus.cancel    = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        n_checks += 4;
        if (bus.credit !== 4'd0) begin n_fail++; $display("FAIL reset_credit got %0d exp 0", bus.credit); end
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        if (bus.dispense !== 1'b0 || bus.nickel_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_outs got disp=%b nick=%b exp 0/0", bus.dispense, bus.nickel_out);
        end
        if (bus.coin_reject !== 1'b0 || bus.sel_error !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulses got rej=%b err=%b exp 0/0", bus.coin_reject, bus.sel_error);
        end
    endtask

    task automatic test_exact_pay();
        do_select(4'b0001);
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL exact_busy got %b exp 1", bus.busy); end
        exp_q.push_back(1); do_coin(1'b1, 1'b0, 1'b0);
        exp = exp_q.pop_front(); n_checks += 2;
        if (bus.credit !== 4'(exp)) begin n_fail++; $display("FAIL exact_credit1 got %0d exp %0d", bus.credit, exp); end
        if (bus.dispense !== 1'b0) begin n_fail++; $display("FAIL exact_early_disp got %b exp 0", bus.dispense); end
        exp_q.push_back(3); do_coin(1'b0, 1'b1, 1'b0);
        exp = exp_q.pop_front(); n_checks += 2;
        if (bus.credit !== 4'(exp)) begin n_fail++; $display("FAIL exact_credit3 got %0d exp %0d", bus.credit, exp); end
        if (bus.dispense !== 1'b1) begin n_fail++; $display("FAIL exact_disp got %b exp 1", bus.dispense); end
        tick(); tick();
        n_checks++;
        if (bus.dispense !== 1'b1) begin n_fail++; $display("FAIL exact_disp_hold got %b exp 1", bus.dispense); end
        base = nick_cnt;
        bus.dispense_ack = 1'b1; tick(); bus.dispense_ack = 1'b0;
        n_checks += 2;
        if (bus.dispense !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL exact_done got disp=%b busy=%b exp 0/0", bus.dispense, bus.busy);
        end
        if (bus.credit !== 4'd0) begin n_fail++; $display("FAIL exact_credit0 got %0d exp 0", bus.credit); end
        tick(); tick(); tick();
        n_checks++;
        if (nick_cnt - base !== 0) begin n_fail++; $display("FAIL exact_nickels got %0d exp 0", nick_cnt - base); end
    endtask

    task automatic test_change();
        do_select(4'b0001);
        exp_q.push_back(2); do_coin(1'b0, 1'b1, 1'b0);
        exp = exp_q.pop_front(); n_checks++;
        if (bus.credit !== 4'(exp)) begin n_fail++; $display("FAIL change_credit2 got %0d exp %0d", bus.credit, exp); end
        exp_q.push_back(4); do_coin(1'b0, 1'b1, 1'b0);
        exp = exp_q.pop_front(); n_checks += 2;
        if (bus.credit !== 4'(exp)) begin n_fail++; $display("FAIL change_credit4 got %0d exp %0d", bus.credit, exp); end
        if (bus.dispense !== 1'b1) begin n_fail++; $display("FAIL change_disp got %b exp 1", bus.dispense); end
        base = nick_cnt; base_b2b = nick_b2b;
        bus.dispense_ack = 1'b1; tick(); bus.dispense_ack = 1'b0;
        n_checks++;
        if (bus.credit !== 4'd1 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL change_enter got credit=%0d busy=%b exp 1/1", bus.credit, bus.busy);
        end
        for (int i = 0; i < 20; i++) begin
            if (!bus.busy) break;
            tick();
        end
        n_checks += 3;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL change_timeout got busy=%b exp 0", bus.busy); end
        if (nick_cnt - base !== 1) begin n_fail++; $display("FAIL change_nickels got %0d exp 1", nick_cnt - base); end
        if (bus.credit !== 4'd0) begin n_fail++; $display("FAIL change_credit0 got %0d exp 0", bus.credit); end
    endtask

    task automatic test_bad_select();
        do_select(4'b0011);
        n_checks += 2;
        if (bus.sel_error !== 1'b1) begin n_fail++; $display("FAIL badsel_err got %b exp 1", bus.sel_error); end
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL badsel_busy got %b exp 0", bus.busy); end
        tick();
        n_checks++;
        if (bus.sel_error !== 1'b0) begin n_fail++; $display("FAIL badsel_pulse got %b exp 0", bus.sel_error); end
        do_select(4'b0000);
        n_checks++;
        if (bus.sel_error !== 1'b1) begin n_fail++; $display("FAIL zerosel_err got %b exp 1", bus.sel_error); end
        do_coin(1'b1, 1'b0, 1'b0);
        n_checks += 2;
        if (bus.coin_reject !== 1'b1) begin n_fail++; $display("FAIL idle_reject got %b exp 1", bus.coin_reject); end
        if (bus.credit !== 4'd0) begin n_fail++; $display("FAIL idle_credit got %0d exp 0", bus.credit); end
        tick();
        n_checks++;
        if (bus.coin_reject !== 1'b0) begin n_fail++; $display("FAIL idle_reject_pulse got %b exp 0", bus.coin_reject); end
    endtask

    task automatic test_both_coins();
        do_select(4'b1000);
        do_select(4'b0011);
        n_checks++;
        if (bus.sel_error !== 1'b0) begin n_fail++; $display("FAIL busy_sel_err got %b exp 0", bus.sel_error); end
        exp_q.push_back(3); do_coin(1'b1, 1'b1, 1'b0);
        exp = exp_q.pop_front(); n_checks += 2;
        if (bus.credit !== 4'(exp)) begin n_fail++; $display("FAIL both_credit3 got %0d exp %0d", bus.credit, exp); end
        if (bus.coin_reject !== 1'b0) begin n_fail++; $display("FAIL both_reject got %b exp 0", bus.coin_reject); end
        exp_q.push_back(5); do_coin(1'b0, 1'b1, 1'b0);
        exp_q.push_back(7); do_coin(1'b0, 1'b1, 1'b0);
        exp = exp_q.pop_front(); exp = exp_q.pop_front(); n_checks += 2;
        if (bus.credit !== 4'(exp)) begin n_fail++; $display("FAIL both_credit7 got %0d exp %0d", bus.credit, exp); end
        if (bus.dispense !== 1'b1) begin n_fail++; $display("FAIL both_disp got %b exp 1", bus.dispense); end
        do_coin(1'b1, 1'b0, 1'b0);
        n_checks += 2;
        if (bus.coin_reject !== 1'b1) begin n_fail++; $display("FAIL vend_reject got %b exp 1", bus.coin_reject); end
        if (bus.credit !== 4'd7) begin n_fail++; $display("FAIL vend_credit got %0d exp 7", bus.credit); end
        base = nick_cnt;
        bus.dispense_ack = 1'b1; tick(); bus.dispense_ack = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!bus.busy) break;
            tick();
        end
        n_checks += 2;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL both_timeout got busy=%b exp 0", bus.busy); end
        if (nick_cnt - base !== 1) begin n_fail++; $display("FAIL both_nickels got %0d exp 1", nick_cnt - base); end
    endtask

    task automatic test_cancel();
        do_select(4'b0100);
        exp_q.push_back(2); do_coin(1'b0, 1'b1, 1'b0);
        exp = exp_q.pop_front(); n_checks++;
        if (bus.credit !== 4'(exp)) begin n_fail++; $display("FAIL cancel_credit2 got %0d exp %0d", bus.credit, exp); end
        base = nick_cnt; base_b2b = nick_b2b;
        do_coin(1'b0, 1'b0, 1'b1);
`ifdef VEND_CANCEL_EN
        for (int i = 0; i < 20; i++) begin
            if (!bus.busy) break;
            tick();
        end
        n_checks += 4;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL refund_timeout got busy=%b exp 0", bus.busy); end
        if (nick_cnt - base !== 2) begin n_fail++; $display("FAIL refund_nickels got %0d exp 2", nick_cnt - base); end
        if (nick_b2b - base_b2b !== 0) begin n_fail++; $display("FAIL refund_spacing got %0d exp 0", nick_b2b - base_b2b); end
        if (bus.credit !== 4'd0) begin n_fail++; $display("FAIL refund_credit got %0d exp 0", bus.credit); end
        // Cancel with zero credit returns straight to IDLE
        do_select(4'b0001);
        do_coin(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL cancel_zero got busy=%b exp 0", bus.busy); end
        // Coin with cancel is credited then refunded
        base = nick_cnt;
        do_select(4'b0001);
        do_coin(1'b1, 1'b0, 1'b1);
        n_checks++;
        if (bus.credit !== 4'd1 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL cancel_coin got credit=%0d busy=%b exp 1/1", bus.credit, bus.busy);
        end
        for (int i = 0; i < 20; i++) begin
            if (!bus.busy) break;
            tick();
        end
        n_checks++;
        if (nick_cnt - base !== 1 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL cancel_coin_refund got nickels=%0d busy=%b exp 1/0", nick_cnt - base, bus.busy);
        end
`else
        tick(); tick(); tick();
        n_checks += 3;
        if (bus.credit !== 4'd2) begin n_fail++; $display("FAIL nocancel_credit got %0d exp 2", bus.credit); end
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL nocancel_busy got %b exp 1", bus.busy); end
        if (nick_cnt - base !== 0) begin n_fail++; $display("FAIL nocancel_nickels got %0d exp 0", nick_cnt - base); end
        // Coin with cancel is just a coin
        exp_q.push_back(3); do_coin(1'b1, 1'b0, 1'b1);
        exp = exp_q.pop_front(); n_checks++;
        if (bus.credit !== 4'(exp) || bus.dispense !== 1'b0) begin
            n_fail++; $display("FAIL nocancel_coin got credit=%0d disp=%b exp %0d/0", bus.credit, bus.dispense, exp);
        end
        do_reset();
`endif
    endtask

    task automatic test_reset_mid();
        do_select(4'b0001);
        exp_q.push_back(2); do_coin(1'b0, 1'b1, 1'b0);
        exp_q.push_back(5); do_coin(1'b1, 1'b1, 1'b0);
        exp = exp_q.pop_front(); exp = exp_q.pop_front(); n_checks++;
        if (bus.credit !== 4'(exp) || bus.dispense !== 1'b1) begin
            n_fail++; $display("FAIL rmid_credit got %0d disp=%b exp %0d/1", bus.credit, bus.dispense, exp);
        end
        base = nick_cnt;
        bus.dispense_ack = 1'b1; tick(); bus.dispense_ack = 1'b0;
        n_checks++;
        if (bus.credit !== 4'd2 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL rmid_change got credit=%0d busy=%b exp 2/1", bus.credit, bus.busy);
        end
        reset = 1'b1; bus.nickel_in = 1'b1; bus.select = 1'b1; bus.item_number = 4'b0011;
        tick();
        reset = 1'b0; bus.nickel_in = 1'b0; bus.select = 1'b0; bus.item_number = 4'b0000;
        n_checks += 2;
        if (bus.busy !== 1'b0 || bus.credit !== 4'd0) begin
            n_fail++; $display("FAIL rmid_state got busy=%b credit=%0d exp 0/0", bus.busy, bus.credit);
        end
        if (bus.nickel_out !== 1'b0 || bus.coin_reject !== 1'b0 || bus.sel_error !== 1'b0) begin
            n_fail++; $display("FAIL rmid_outs got nick=%b rej=%b err=%b exp 0", bus.nickel_out, bus.coin_reject, bus.sel_error);
        end
        for (int i = 0; i < 6; i++) tick();
        n_checks++;
        if (nick_cnt - base !== 0) begin n_fail++; $display("FAIL rmid_nickels got %0d exp 0", nick_cnt - base); end
    endtask

    initial begin
        reset = 1'b1;
        bus.item_number = 4'b0000; bus.select = 1'b0; bus.nickel_in = 1'b0;
        bus.dime_in = 1'b0; bus.cancel = 1'b0; bus.dispense_ack = 1'b0;
        test_reset();
        test_exact_pay();
        test_change();
        test_bad_select();
        test_both_coins();
        test_cancel();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_left got %0d exp 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "timeout");
    end
endmodule
